booth_mul_seq: RTL and testbench

- Sequential radix-2 Booth multiplier for the operating block.
- Multiplies two N-bit two's-complement operands (RA × RB) into a 2N-bit product over N add/shift cycles.
- Contains the ±RA sign-extending adder-input selector as a sub-module. Handshake is start/busy/done, towards the control unit.

---
 rtl/booth_pkg.sv | 20 ++
 rtl/booth_addsub.sv | 39 +++
 rtl/booth_mul_seq.sv | 130 +++++++++++++
 tb/tb_booth_mul_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package booth_pkg;

  // Default operand width in bits.
  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth recoding of {Q[0], q_1}: what the adder does with M this step.
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_addsub.sv
// Booth adder-input selector and adder: sum = A + M, A - M (as A + ~M + 1) or A.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   m    [N:0]  sign-extended multiplicand
//   a    [N:0]  accumulator
//   code [1:0]  Booth code (BOOTH_NOP / BOOTH_ADD / BOOTH_SUB)
//   sum  [N:0]  accumulator after the selected add/subtract
module booth_addsub
  import booth_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N:0] m,
  input  logic [N:0] a,
  input  logic [1:0] code,
  output logic [N:0] sum
);

  logic [N:0] operand;
  logic       cin;

  always_comb begin
    operand = '0;
    cin     = 1'b0;
    case (code)
      BOOTH_ADD: operand = m;
      BOOTH_SUB: begin
        // Two's-complement negate folded into the adder via carry-in.
        operand = ~m;
        cin     = 1'b1;
      end
      default: ;
    endcase
    sum = a + operand + {{N{1'b0}}, cin};
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: signed N x N -> 2N product, one add/shift per cycle.
// Latency: start sampled at T, busy T+1..T+N, done pulse at T+N+1, idle again at T+N+2.
// Backpressure: none; start is only sampled in IDLE, ignored while busy or done.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              begin a multiplication (sampled only in IDLE)
//   ra, rb     [N-1:0] multiplicand / multiplier, two's complement
//   busy               high while iterating
//   done               one-cycle pulse, product valid
//   product  [2N-1:0]  signed result, held until overwritten by the next result
//   step     [CW-1:0]  completed iteration count (0..N)
//
// Optional feature macro: BOOTH_ZERO_BYPASS_EN -- a zero operand skips the
// iterations and goes straight to DONE with product 0 and step 0.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int CW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N-1:0]    ra,
  input  logic [N-1:0]    rb,
  output logic            busy,
  output logic            done,
  output logic [2*N-1:0]  product,
  output logic [CW-1:0]   step
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state, state_nxt;

  // M and A carry an extra sign bit so that -M is representable for ra = -2^(N-1).
  logic [N:0]   m;
  logic [N:0]   a;
  logic [N-1:0] q;
  logic         q1;

  logic [1:0]   code;
  logic [N:0]   sum;
  logic [N:0]   a_sh;
  logic [N-1:0] q_sh;
  logic         last;
  logic         bypass;

`ifdef BOOTH_ZERO_BYPASS_EN
  assign bypass = (ra == '0) || (rb == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    case ({q[0], q1})
      2'b01:   code = BOOTH_ADD;
      2'b10:   code = BOOTH_SUB;
      default: code = BOOTH_NOP;
    endcase
  end

  booth_addsub #(.N(N)) u_addsub (
    .m    (m),
    .a    (a),
    .code (code),
    .sum  (sum)
  );

  // Arithmetic right shift of the whole {A, Q, q_1} word; A's sign bit is replicated.
  assign a_sh = {sum[N], sum[N:1]};
  assign q_sh = {sum[0], q[N-1:1]};
  assign last = (step == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = bypass ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m       <= '0;
      a       <= '0;
      q       <= '0;
      q1      <= 1'b0;
      step    <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          m    <= {ra[N-1], ra};
          q    <= rb;
          a    <= '0;
          q1   <= 1'b0;
          step <= '0;
          if (bypass) product <= '0;
        end
        CALC: begin
          a    <= a_sh;
          q    <= q_sh;
          q1   <= q[0];
          step <= step + 1'b1;
          // Final iteration: capture the shifted result directly.
          if (last) product <= {a_sh[N-1:0], q_sh};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Testbench for booth_mul_seq (N=4): timeline model plus directed vectors.
// Latency: n/a.
// Backpressure: n/a.
module tb_booth_mul_seq;

  localparam int N  = 4;
  localparam int CW = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  ra    = '0;
  logic [N-1:0]  rb    = '0;
  logic          busy;
  logic          done;
  logic [2*N-1:0] product;
  logic [CW-1:0] step;

  int checks = 0;
  int errors = 0;

  booth_mul_seq #(.N(N), .CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ra      (ra),
    .rb      (rb),
    .busy    (busy),
    .done    (done),
    .product (product),
    .step    (step)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: an accepted operation is described only by the number of clock
  // edges elapsed since it was accepted, and its arithmetic result.
  bit                active = 1'b0;
  bit                byp    = 1'b0;
  int                e      = 0;
  logic signed [2*N-1:0] val   = '0;
  logic [2*N-1:0]    mprod  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active = 1'b0;
      byp    = 1'b0;
      e      = 0;
      mprod  = '0;
    end else if ((!active || e >= N + 1) && start) begin
      active = 1'b1;
      val    = $signed(ra) * $signed(rb);
`ifdef BOOTH_ZERO_BYPASS_EN
      byp    = (ra == 0) || (rb == 0);
`else
      byp    = 1'b0;
`endif
      e      = byp ? N : 0;
      if (byp) mprod = '0;
    end else if (active && e <= N) begin
      e = e + 1;
      if (e == N) mprod = val;
    end
  end

  logic          exp_busy;
  logic          exp_done;
  logic [CW-1:0] exp_step;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_busy = active && !byp && (e < N);
      exp_done = active && (e == N);
      if (!active || byp) exp_step = '0;
      else if (e < N)     exp_step = CW'(e);
      else                exp_step = CW'(N);
      check("cyc_busy", 32'(busy), 32'(exp_busy));
      check("cyc_done", 32'(done), 32'(exp_done));
      check("cyc_step", 32'(step), 32'(exp_step));
      check("cyc_product", 32'(product), 32'(mprod));
    end
  end

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2*N-1:0] expp, input int explat,
                       input int expbusy, input string name);
    int lat;
    int nb;
    @(negedge clk);
    ra    = a;
    rb    = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    nb    = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) nb++;
    end
    check({name, "_latency"}, 32'(lat), 32'(explat));
    check({name, "_product"}, 32'(product), 32'(expp));
    check({name, "_busycycles"}, 32'(nb), 32'(expbusy));
    check({name, "_modelpin"}, 32'(mprod), 32'(expp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int lat2;

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    check("reset_step", 32'(step), 32'd0);
    rst_n = 1'b1;

    do_op(4'd3, 4'd5, 8'h0F, 5, 4, "pos_3x5");
    @(negedge clk);
    check("step_hold_idle", 32'(step), 32'd4);
    do_op(4'hD, 4'd5, 8'hF1, 5, 4, "neg3x5");
    do_op(4'd7, 4'h8, 8'hC8, 5, 4, "7xneg8");
    do_op(4'h8, 4'h8, 8'h40, 5, 4, "neg8xneg8");
    do_op(4'h8, 4'd1, 8'hF8, 5, 4, "neg8x1");

    // start held high: second result must come N+2 cycles after the first,
    // and operand changes during CALC must not leak into either result.
    @(negedge clk);
    ra    = 4'd2;
    rb    = 4'd3;
    start = 1'b1;
    lat   = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        ra = 4'd7;
        rb = 4'd7;
      end
    end
    check("hs_first_latency", 32'(lat), 32'd5);
    check("hs_first_product", 32'(product), 32'h06);
    lat2 = 0;
    do begin
      @(negedge clk);
      lat2++;
      if (lat2 == 3) begin
        ra = 4'd1;
        rb = 4'd1;
      end
    end while (!done && lat2 < 20);
    start = 1'b0;
    check("hs_second_spacing", 32'(lat2), 32'd6);
    check("hs_second_product", 32'(product), 32'h31);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    ra    = 4'd3;
    rb    = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_product", 32'(product), 32'd0);
    check("midreset_step", 32'(step), 32'd0);
    @(negedge clk);
    check("midreset_stays_idle", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;

    do_op(4'hD, 4'd5, 8'hF1, 5, 4, "after_reset");

`ifdef BOOTH_ZERO_BYPASS_EN
    do_op(4'd0, 4'hB, 8'h00, 1, 0, "zero_op");
    check("zero_op_step", 32'(step), 32'd0);
`else
    do_op(4'd0, 4'hB, 8'h00, 5, 4, "zero_op");
    check("zero_op_step", 32'(step), 32'd4);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
